// File: rtl/sr_pulse_driver.sv
// Write-side driver for a NOR SR latch: turns set/reset commands into fixed-width S/R pulses
// followed by dead time, tracks the expected latch state and flags feedback disagreement.
module sr_pulse_driver #(
  parameter int PULSE_W        = 2,
  parameter int GAP_W          = 2,
  parameter bit SKIP_REDUNDANT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_valid,
  input  logic cmd_set,
  output logic cmd_ready,
  output logic S,
  output logic R,
  input  logic q_fb,
  output logic q_model,
  output logic busy,
  output logic fault
);

  localparam int MAX_W = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CW    = $clog2(MAX_W + 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP_W - 1);

  typedef enum logic [1:0] {INIT, PULSE, GAP, IDLE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          s_nxt, r_nxt, q_model_nxt, fault_nxt;
  logic          q_meta, q_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INIT;
      cnt     <= '0;
      S       <= 1'b0;
      R       <= 1'b0;
      q_model <= 1'b0;
      fault   <= 1'b0;
      q_meta  <= 1'b0;
      q_sync  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      S       <= s_nxt;
      R       <= r_nxt;
      q_model <= q_model_nxt;
      fault   <= fault_nxt;
      q_meta  <= q_fb;
      q_sync  <= q_meta;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    s_nxt       = S;
    r_nxt       = R;
    q_model_nxt = q_model;
    fault_nxt   = fault;
    cmd_ready   = 1'b0;
    busy        = 1'b1;
    case (state)
      INIT: begin
        state_nxt = PULSE;
        s_nxt     = 1'b0;
        r_nxt     = 1'b1;
        cnt_nxt   = PULSE_LD;
      end
      PULSE: begin
        if (cnt == '0) begin
          // S still holds the commanded value here (0 for the power-on R pulse)
          state_nxt   = GAP;
          s_nxt       = 1'b0;
          r_nxt       = 1'b0;
          q_model_nxt = S;
          cnt_nxt     = GAP_LD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (q_sync != q_model) begin
          fault_nxt = 1'b1;
        end
        if (cmd_valid && !(SKIP_REDUNDANT && (cmd_set == q_model))) begin
          state_nxt = PULSE;
          s_nxt     = cmd_set;
          r_nxt     = ~cmd_set;
          cnt_nxt   = PULSE_LD;
        end
      end
      default: state_nxt = INIT;
    endcase
  end

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Scoreboarded bench: commands push expected pulses, a negedge monitor checks the S/R waveforms.
module tb_sr_pulse_driver;

  localparam int P = 2;
  localparam int G = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_set = 1'b0;
  logic cmd_ready, S, R, q_fb, q_model, busy, fault;
  logic ns_valid = 1'b0, ns_set = 1'b0;
  logic ns_ready, ns_S, ns_R, ns_q_fb, ns_q_model, ns_busy, ns_fault;

  logic q_lat = 1'b0, ns_q_lat = 1'b0, force_fb = 1'b0;

  always #5 clk = ~clk;

  sr_pulse_driver #(.PULSE_W(P), .GAP_W(G), .SKIP_REDUNDANT(1'b1)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_set(cmd_set), .cmd_ready(cmd_ready),
    .S(S), .R(R), .q_fb(q_fb), .q_model(q_model), .busy(busy), .fault(fault));

  sr_pulse_driver #(.PULSE_W(P), .GAP_W(G), .SKIP_REDUNDANT(1'b0)) u_dut_ns (
    .clk(clk), .rst(rst), .cmd_valid(ns_valid), .cmd_set(ns_set), .cmd_ready(ns_ready),
    .S(ns_S), .R(ns_R), .q_fb(ns_q_fb), .q_model(ns_q_model), .busy(ns_busy), .fault(ns_fault));

  // Behavioural NOR latches driven by each DUT
  always @(S, R) begin
    if (S && !R) q_lat = 1'b1;
    else if (R && !S) q_lat = 1'b0;
  end
  always @(ns_S, ns_R) begin
    if (ns_S && !ns_R) ns_q_lat = 1'b1;
    else if (ns_R && !ns_S) ns_q_lat = 1'b0;
  end
  assign q_fb    = force_fb ? 1'b0 : q_lat;
  assign ns_q_fb = ns_q_lat;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;

  typedef struct {
    logic set;
    logic q;
    int   start;
  } exp_t;
  exp_t exp_q[$];
  logic mq = 1'b0;
  int   red_cnt = 0;

  task automatic fail(input string name, input int act, input int req);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic chk(input string name, input int act, input int req);
    if (act != req) fail(name, act, req);
    else n_cmp++;
  endtask

  // Monitor: each pulse on S/R must match the next expected entry in shape and timing
  int   mon_phase = 0, mon_cnt = 0;
  logic mon_q = 1'b0;
  exp_t cur;
  always @(negedge clk) begin
    if (rst) begin
      mon_phase = 0;
      mon_q     = 1'b0;
    end else begin
      n_cmp++;
      assert (!(S && R)) else begin
        n_bad++;
        $display("FAIL sr_exclusive: got S=%0b R=%0b, expected not both", S, R);
      end
      case (mon_phase)
        0: begin
          chk("q_model_idle", int'(q_model), int'(mon_q));
          if (S || R) begin
            if (exp_q.size() == 0) begin
              fail("unexpected_pulse", int'(S) * 2 + int'(R), 0);
            end else begin
              cur = exp_q.pop_front();
              chk("pulse_start_cycle", cyc, cur.start);
              chk("pulse_S", int'(S), int'(cur.set));
              chk("pulse_R", int'(R), int'(!cur.set));
              mon_phase = 1;
              mon_cnt   = 1;
            end
          end
        end
        1: begin
          if (mon_cnt < P) begin
            chk("pulse_hold_S", int'(S), int'(cur.set));
            chk("pulse_hold_R", int'(R), int'(!cur.set));
            mon_cnt++;
          end else begin
            chk("pulse_end", int'(S | R), 0);
            chk("q_model_update", int'(q_model), int'(cur.q));
            chk("ready_in_gap", int'(cmd_ready), 0);
            mon_q     = cur.q;
            mon_phase = 2;
            mon_cnt   = 1;
          end
        end
        default: begin
          if (mon_cnt < G) begin
            chk("gap_quiet", int'(S | R), 0);
            chk("ready_in_gap", int'(cmd_ready), 0);
            mon_cnt++;
          end else begin
            chk("ready_return", int'(cmd_ready), 1);
            chk("busy_clear", int'(busy), 0);
            mon_phase = 0;
          end
        end
      endcase
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input logic s);
    int w = 0;
    cmd_valid = 1'b1;
    cmd_set   = s;
    while (!cmd_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      fail("accept_timeout", w, 0);
    end else if (s == mq) begin
      red_cnt++;
    end else begin
      exp_q.push_back('{set: s, q: s, start: cyc + 1});
      mq = s;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((exp_q.size() != 0 || mon_phase != 0 || !cmd_ready) && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) fail("idle_timeout", w, 0);
  endtask

  task automatic release_rst();
    rst = 1'b0;
    mq  = 1'b0;
    exp_q.push_back('{set: 1'b0, q: 1'b0, start: cyc + 1});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, r0, acc, sc, rc, w;
    logic b;

    repeat (3) @(negedge clk);
    chk("rst_S", int'(S), 0);
    chk("rst_R", int'(R), 0);
    chk("rst_ready", int'(cmd_ready), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_q_model", int'(q_model), 0);
    chk("rst_fault", int'(fault), 0);

    release_rst();
    wait_idle();
    chk("init_q_model", int'(q_model), 0);

    // directed set then reset
    send(1'b1);
    wait_idle();
    send(1'b0);
    wait_idle();

    // redundant sets accepted one per cycle with no pulse
    send(1'b1);
    wait_idle();
    t  = cyc;
    r0 = red_cnt;
    send(1'b1);
    send(1'b1);
    send(1'b1);
    chk("redundant_cycles", cyc - t, 3);
    chk("redundant_count", red_cnt - r0, 3);
    wait_idle();

    // alternating stream with valid held through busy periods
    for (int i = 0; i < 6; i++) send(1'(i % 2));
    wait_idle();

    // random commands against the real latch
    for (int i = 0; i < 20; i++) begin
      b = 1'($urandom_range(0, 1));
      send(b);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();
    chk("fault_clean", int'(fault), 0);
    chk("q_model_vs_ref", int'(q_model), int'(mq));

    // SKIP_REDUNDANT=0: every set pulses, one per P+G+1 cycles
    w = 0;
    while (!ns_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!ns_ready) fail("ns_idle_timeout", w, 0);
    ns_valid = 1'b1;
    ns_set   = 1'b1;
    acc = 0; sc = 0; rc = 0;
    for (int i = 0; i < 4 * (P + G + 1); i++) begin
      if (ns_ready) acc++;
      if (ns_S) sc++;
      if (ns_R) rc++;
      @(negedge clk);
    end
    ns_valid = 1'b0;
    chk("ns_accepts", acc, 4);
    chk("ns_S_cycles", sc, 4 * P);
    chk("ns_R_cycles", rc, 0);
    chk("ns_q_model", int'(ns_q_model), 1);

    // feedback forced low after a set
    send(1'b1);
    wait_idle();
    chk("fault_pre", int'(fault), 0);
    force_fb = 1'b1;
    w = 0;
    while (!fault && w < 3) begin
      @(negedge clk);
      w++;
    end
    chk("fault_latency", int'(fault), 1);
    repeat (5) @(negedge clk);
    force_fb = 1'b0;
    repeat (3) @(negedge clk);
    chk("fault_sticky", int'(fault), 1);

    // reset in the middle of an S pulse
    send(1'b0);
    wait_idle();
    send(1'b1);
    chk("s_before_rst", int'(S), 1);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_S", int'(S), 0);
    chk("midrst_R", int'(R), 0);
    chk("midrst_q_model", int'(q_model), 0);
    chk("midrst_fault", int'(fault), 0);
    chk("midrst_ready", int'(cmd_ready), 0);
    @(negedge clk);
    release_rst();
    wait_idle();
    chk("post_rst_fault", int'(fault), 0);
    chk("post_rst_q_model", int'(q_model), 0);
    repeat (4) @(negedge clk);
    chk("post_rst_fault_idle", int'(fault), 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
